// File: rtl/piso_serial_ctrl.sv
// rtl/piso_serial_ctrl.sv - sequencer for a WIDTH-bit PISO shift register, MSB-first framed serial out
// Optional even-parity trailer bit is built when PISO_PARITY_EN is defined.
module piso_serial_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic             sr_sl,
  output logic [WIDTH-1:0] sr_b,
  input  logic             sr_q_msb,
  output logic             ser_data,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
`ifdef PISO_PARITY_EN
    ,
    PARITY
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [CW-1:0]    count_q, count_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      word_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    count_d   = count_q;
    in_ready  = 1'b0;
    sr_sl     = 1'b0;
    sr_b      = '0;
    ser_data  = 1'b0;
    ser_valid = 1'b0;
    ser_first = 1'b0;
    ser_last  = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = !flush;
        if (in_valid && !flush) begin
          word_d  = in_data;
          state_d = LOAD;
        end
      end

      LOAD: begin
        sr_b    = word_q;
        count_d = '0;
        state_d = SHIFT;
      end

      SHIFT: begin
        sr_sl     = 1'b1;
        sr_b      = word_q;
        ser_valid = 1'b1;
        ser_data  = sr_q_msb;
        ser_first = (count_q == '0);
        if (count_q == LAST_CNT) begin
          count_d = '0;
`ifdef PISO_PARITY_EN
          state_d = PARITY;
`else
          ser_last = 1'b1;
          state_d  = IDLE;
`endif
        end else begin
          count_d = count_q + 1'b1;
        end
      end

`ifdef PISO_PARITY_EN
      PARITY: begin
        sr_sl     = 1'b1;
        sr_b      = word_q;
        ser_valid = 1'b1;
        ser_last  = 1'b1;
        ser_data  = ^word_q;
        state_d   = IDLE;
      end
`endif

      default: state_d = IDLE;
    endcase

    // Abort wins over everything; the partial frame is left without a last marker.
    if (flush) begin
      state_d   = IDLE;
      count_d   = '0;
      ser_valid = 1'b0;
      ser_first = 1'b0;
      ser_last  = 1'b0;
    end
  end

  assign busy = (state_q != IDLE);

endmodule
